// File: rtl/cache_controller.sv
// Direct-mapped, write-through, write-allocate cache controller fronting a
// fixed-latency RAM; one request outstanding at a time.
module cache_controller #(
  parameter int LINES       = 16,
  parameter int RAM_WORDS   = 4096,
  parameter int RAM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic        cpu_write,
  input  logic [0:31] cpu_address,
  input  logic [0:31] cpu_data,
  output logic        cpu_resp_valid,
  output logic [0:31] cpu_out,
  output logic        cpu_hit,
  output logic [0:15] hit_count,
  output logic [0:15] miss_count,
  output logic [0:31] ram_address,
  output logic [0:31] ram_data,
  output logic        ram_write,
  input  logic [0:31] ram_out
);

  localparam int IW = $clog2(LINES);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int TW = AW - IW;
  localparam logic [2:0] LAST = 3'(RAM_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE, S_RESP} state_t;

  state_t r_state, w_next;

  logic [31:0]    w_addr, w_wdata, w_ram_out;
  logic [IW-1:0]  w_idx, w_ridx;
  logic [TW-1:0]  w_tag, w_rtag;
  logic           w_hit, w_fill, w_last;

  logic [LINES-1:0] r_valid;
  logic [TW-1:0]    r_tag  [LINES];
  logic [31:0]      r_data [LINES];

  logic        r_wr, r_rdhit, r_resp_valid, r_hit_o, r_ram_wr;
  logic [31:0] r_addr, r_wdata, r_rdata, r_out, r_ram_addr, r_ram_data;
  logic [2:0]  r_cnt;
  logic [15:0] r_hits, r_misses;

  // Internal arithmetic uses descending vectors; value is unchanged.
  assign w_addr    = cpu_address;
  assign w_wdata   = cpu_data;
  assign w_ram_out = ram_out;

  assign w_idx  = w_addr[IW-1:0];
  assign w_tag  = w_addr[AW-1:IW];
  assign w_ridx = r_addr[IW-1:0];
  assign w_rtag = r_addr[AW-1:IW];
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_last = (r_cnt == LAST);
  assign w_fill = ((r_state == S_FETCH) && w_last) || (r_state == S_WRITE);

  assign cpu_req_ready  = (r_state == S_IDLE);
  assign cpu_resp_valid = r_resp_valid;
  assign cpu_out        = r_out;
  assign cpu_hit        = r_hit_o;
  assign hit_count      = r_hits;
  assign miss_count     = r_misses;
  assign ram_address    = r_ram_addr;
  assign ram_data       = r_ram_data;
  assign ram_write      = r_ram_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (cpu_req_valid)
                 w_next = cpu_write ? S_WRITE : (w_hit ? S_RESP : S_FETCH);
      S_FETCH: if (w_last) w_next = S_RESP;
      S_WRITE: w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr         <= 1'b0;
      r_rdhit      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_hit_o      <= 1'b0;
      r_out        <= '0;
      r_ram_addr   <= '0;
      r_ram_data   <= '0;
      r_ram_wr     <= 1'b0;
      r_hits       <= '0;
      r_misses     <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_ram_wr     <= 1'b0;
      case (r_state)
        S_IDLE: if (cpu_req_valid) begin
          r_wr    <= cpu_write;
          r_addr  <= w_addr;
          r_wdata <= w_wdata;
          r_rdhit <= !cpu_write && w_hit;
          r_cnt   <= '0;
          if (cpu_write) begin
            r_ram_addr <= w_addr;
            r_ram_data <= w_wdata;
            r_ram_wr   <= 1'b1;
          end else if (w_hit) begin
            r_rdata <= r_data[w_idx];
            if (r_hits != 16'hFFFF) r_hits <= r_hits + 16'd1;
          end else begin
            r_ram_addr <= w_addr;
            if (r_misses != 16'hFFFF) r_misses <= r_misses + 16'd1;
          end
        end
        S_FETCH: begin
          if (w_last) r_rdata <= w_ram_out;
          else        r_cnt   <= r_cnt + 3'd1;
        end
        S_RESP: begin
          r_resp_valid <= 1'b1;
          r_hit_o      <= r_rdhit;
          r_out        <= r_wr ? r_wdata : r_rdata;
        end
        default: ;
      endcase
    end
  end

  // Valid bits are the only line state that reset must clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_valid        <= '0;
    else if (w_fill) r_valid[w_ridx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_ridx]  <= w_rtag;
      r_data[w_ridx] <= (r_state == S_WRITE) ? r_wdata : w_ram_out;
    end
  end

endmodule

// File: doc/cache_controller.md
# cache_controller

Direct-mapped, write-through, write-allocate cache controller that sits between the CPU request port and the `ram` block. It is the initiator of the RAM's `address`/`data`/`write`/`out` interface. It serves read hits from a local line array and forwards every write to RAM. Read misses fetch the word from RAM with a fixed, parameterised read latency.

## Interface
Parameters:
- `LINES`, 16: number of one-word lines; power of two, 2..256.
- `RAM_WORDS`, 4096: RAM depth; power of two. RAM aliases addresses modulo this value.
- `RAM_LATENCY`, 1: edges from driving `ram_address` (write=0) to valid `ram_out`; range 1..7.

Ports (all vectors declared `[0:N-1]`; bit 0 is the MSB):
- `clk` in 1: single clock; all state changes on posedge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `cpu_req_valid` in 1: request present.
- `cpu_req_ready` out 1: controller accepts a request this cycle.
- `cpu_write` in 1: 1 = write, 0 = read.
- `cpu_address` in 32: word address.
- `cpu_data` in 32: write data.
- `cpu_resp_valid` out 1: one-cycle response pulse; no backpressure.
- `cpu_out` out 32: read data, or the written data for writes.
- `cpu_hit` out 1: qualifies `cpu_resp_valid`; 1 = read hit.
- `hit_count`, `miss_count` out 16: read hit/miss counters, saturating at 65535.
- `ram_address` out 32: RAM address.
- `ram_data` out 32: RAM write data.
- `ram_write` out 1: RAM write enable; RAM commits on the posedge where it is 1.
- `ram_out` in 32: RAM read data.

## Operation
- Effective address `ea = cpu_address mod RAM_WORDS`.
- `index = ea mod LINES`.
- `tag = ea / LINES`, width log2(RAM_WORDS) − log2(LINES) (8 bits at defaults).
- Aliased CPU addresses (e.g. 2816867292 and 3036) therefore share one line and one tag.
- Each line holds `valid`, `tag` and 32-bit `data`.

States:
- IDLE:
  - `cpu_req_ready` = 1.
  - Accept when `cpu_req_valid` is 1; latch write, ea and data.
  - Read hit → RESP.
  - Read miss → FETCH.
  - Write → WRITE.
- FETCH:
  - `ram_address` = ea, `ram_write` = 0.
  - A 3-bit counter counts `RAM_LATENCY` edges.
  - On the final edge, sample `ram_out`: fill the line (valid=1, tag, data) and latch it as response data → RESP.
- WRITE:
  - `ram_address` = ea, `ram_data` = data, `ram_write` = 1 for exactly one cycle.
  - On that edge write the line (valid=1, tag, data), whether hit or miss → RESP.
- RESP:
  - `cpu_resp_valid` = 1 for one cycle.
  - `cpu_hit` = 1 only for a read hit.
  - → IDLE.

Other rules:
- `cpu_req_ready` = (state == IDLE). At most one request is outstanding.
- `hit_count` increments on read hits; `miss_count` on read misses. Writes are not counted. Both counters hold at 65535.
- Outside FETCH/WRITE: `ram_write` = 0; `ram_address` and `ram_data` hold their last values.
- `cpu_out` holds its last value outside RESP.

## Timing
- All outputs are registered except `cpu_req_ready`, which is decoded from state.
- Reset values:
  - State IDLE, all line valid bits 0.
  - `cpu_req_ready` = 1; CPU must not request while `rst_n` is 0.
  - `cpu_resp_valid`, `cpu_hit` and `ram_write` = 0.
  - `cpu_out`, `ram_address`, `ram_data` = 0.
  - Counters = 0.
- Accept edge is E0. Response is high during the cycle after:
  - Read hit: E1 (latency 1; throughput one per 2 cycles).
  - Read miss: E0+RAM_LATENCY+1.
  - Write: E2; RAM commits at E1.
- A read immediately after a write to the same address hits and returns the new data.
- Reset asserted mid-FETCH or mid-WRITE aborts the transaction:
  - `ram_write` drops asynchronously.
  - No line is filled.
  - No response is issued.
  - A write may or may not have committed in RAM.
- Counter saturation: at 65535 a further hit or miss leaves the value unchanged; no wrap to 0.

## Test plan
- Reset, then read address 0 → miss; RAM returns 14528. `cpu_out` = 14528 with `cpu_hit` = 0 at E0+RAM_LATENCY+1. Re-read → `cpu_hit` = 1, `cpu_out` = 14528 at E1. `hit_count` = 1, `miss_count` = 1.
- Write 526421 to 2816867292 → `ram_write` high one cycle with `ram_address` = 2816867292 and `ram_data` = 526421. Read 3036 (alias) → hit, 526421.
- Conflict: write 25369366 to 2001 (index 1), then write 7 to 17 (index 1). Read 2001 → miss, refetch from RAM returns 25369366. Then read 17 → miss.
- Wrap/boundary: write 2 to 4294967295 (ea 4095, index 15, tag 255). Read 4095 → hit, 2.
- Assert `rst_n` low during FETCH for address 0. Then:
  - `ram_write` = 0 and `cpu_resp_valid` never pulses.
  - After release, read 0 → miss (valid bits cleared).
- Force 65536 read hits to one address → `hit_count` = 65535 and stays at 65535 on further hits.
